// File: rtl/sid_bus_writer.sv
// Register-write initiator for the triple-voice synthesizer bus: queues (voice, addr, data)
// requests and replays each one as setup, a write-enable strobe, then a quiet gap.
module sid_bus_writer #(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_voice,
    input  logic [2:0]                 req_addr,
    input  logic [7:0]                 req_data,
    output logic [2:0]                 bus_addr,
    output logic [1:0]                 bus_voice,
    output logic                       bus_we,
    output logic [7:0]                 bus_data,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       bad_req
);

    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = $clog2(DEPTH + 1);
    localparam int CMAX_A = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CMAX   = (CMAX_A > GAP_CYC) ? CMAX_A : GAP_CYC;
    localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef struct packed {
        logic [1:0] voice;
        logic [2:0] addr;
        logic [7:0] data;
    } req_t;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

    req_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            bad_req_q, bad_req_d;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    req_t            bus_q, bus_d;
    logic            bus_we_q, bus_we_d;

    logic            full, empty, legal, accept, push, pop;

    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign legal  = (req_voice != 2'd3) && (req_addr != 3'd3) && (req_addr != 3'd7);
    assign accept = req_valid && req_ready;
    assign push   = accept && legal;
    // Popping only from IDLE gives the one-edge minimum residency (no bypass path).
    assign pop    = (state_q == IDLE) && !empty;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        bad_req_d = accept && !legal;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bus_d    = bus_q;
        bus_we_d = bus_we_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    bus_d   = mem_q[rd_ptr_q];
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d  = STROBE;
                    cnt_d    = CW'(HOLD_CYC - 1);
                    bus_we_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d  = GAP;
                    cnt_d    = CW'(GAP_CYC - 1);
                    bus_we_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d  = IDLE;
                bus_we_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            bad_req_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_q     <= '0;
            bus_we_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            bad_req_q <= bad_req_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_q     <= bus_d;
            bus_we_q  <= bus_we_d;
        end
    end

    // NOTE: FIFO storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_voice, req_addr, req_data};
    end

    assign req_ready = !full;
    assign bus_voice = bus_q.voice;
    assign bus_addr  = bus_q.addr;
    assign bus_data  = bus_q.data;
    assign bus_we    = bus_we_q;
    assign level     = level_q;
    assign bad_req   = bad_req_q;
    assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_sid_bus_writer.sv
// Directed bench for sid_bus_writer: a default-timing instance and a 1/1/1 timing instance,
// with strobe monitors and a rising-edge capture model standing in for the synthesizer.
module tb_sid_bus_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_valid = 1'b0;
    logic [1:0] a_voice = '0;
    logic [2:0] a_addr  = '0;
    logic [7:0] a_data  = '0;
    logic       a_ready, a_we, a_busy, a_bad;
    logic [2:0] a_baddr, a_level;
    logic [1:0] a_bvoice;
    logic [7:0] a_bdata;

    logic       b_valid = 1'b0;
    logic [1:0] b_voice = '0;
    logic [2:0] b_addr  = '0;
    logic [7:0] b_data  = '0;
    logic       b_ready, b_we, b_busy, b_bad;
    logic [2:0] b_baddr, b_level;
    logic [1:0] b_bvoice;
    logic [7:0] b_bdata;

    sid_bus_writer dut (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready),
        .req_voice(a_voice), .req_addr(a_addr), .req_data(a_data),
        .bus_addr(a_baddr), .bus_voice(a_bvoice), .bus_we(a_we), .bus_data(a_bdata),
        .busy(a_busy), .level(a_level), .bad_req(a_bad)
    );

    sid_bus_writer #(.DEPTH(4), .SETUP_CYC(1), .HOLD_CYC(1), .GAP_CYC(1)) dut_fast (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_voice(b_voice), .req_addr(b_addr), .req_data(b_data),
        .bus_addr(b_baddr), .bus_voice(b_bvoice), .bus_we(b_we), .bus_data(b_bdata),
        .busy(b_busy), .level(b_level), .bad_req(b_bad)
    );

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Strobe monitors: edge index and bus value at each rising edge of bus_we, and high lengths.
    logic        a_prev = 1'b0, b_prev = 1'b0;
    int          a_hi = 0, b_hi = 0;
    int          a_rise_edge[$], b_rise_edge[$];
    logic [12:0] a_rise_val[$];
    int          a_hi_len[$], b_hi_len[$];

    always @(negedge clk) begin
        if (a_we === 1'b1) begin
            if (a_prev !== 1'b1) begin
                a_rise_edge.push_back(edge_cnt);
                a_rise_val.push_back({a_bvoice, a_baddr, a_bdata});
                a_hi = 0;
            end
            a_hi++;
        end else if (a_prev === 1'b1) begin
            a_hi_len.push_back(a_hi);
        end
        a_prev = a_we;

        if (b_we === 1'b1) begin
            if (b_prev !== 1'b1) begin
                b_rise_edge.push_back(edge_cnt);
                b_hi = 0;
            end
            b_hi++;
        end else if (b_prev === 1'b1) begin
            b_hi_len.push_back(b_hi);
        end
        b_prev = b_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge; holds valid until the transfer edge, returns at the following negedge.
    task automatic push(input bit sel, input logic [1:0] v, input logic [2:0] a, input logic [7:0] d);
        int n = 0;
        if (!sel) begin
            a_valid = 1'b1; a_voice = v; a_addr = a; a_data = d;
        end else begin
            b_valid = 1'b1; b_voice = v; b_addr = a; b_data = d;
        end
        while (((sel ? b_ready : a_ready) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_timeout", n, 0);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input int budget);
        int n = 0;
        @(negedge clk);
        while (((sel ? b_busy : a_busy) !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("idle_timeout", n, 0);
        #1;
    endtask

    logic [12:0] burst_vec [6];
    logic [7:0]  regs [3][8];

    initial begin
        int t0, base, hbase, n;
        logic [12:0] val;
        logic [7:0]  other;

        // Reset: outputs at reset values, ready high, pushes ignored.
        a_valid = 1'b1; a_voice = 2'd0; a_addr = 3'd1; a_data = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_bus_addr", a_baddr, 0);
        check("rst_bus_voice", a_bvoice, 0);
        check("rst_bus_data", a_bdata, 0);
        check("rst_bus_we", a_we, 0);
        check("rst_busy", a_busy, 0);
        check("rst_level", a_level, 0);
        check("rst_bad_req", a_bad, 0);
        check("rst_req_ready", a_ready, 1);
        a_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_level", a_level, 0);
        check("post_rst_busy", a_busy, 0);

        // Single write with default timing.
        t0 = edge_cnt + 1;
        push(0, 2'd1, 3'd0, 8'h5A);
        check("w1_e0_we", a_we, 0);
        check("w1_e0_level", a_level, 1);
        check("w1_e0_busy", a_busy, 1);
        @(negedge clk);
        check("w1_e1_voice", a_bvoice, 1);
        check("w1_e1_addr", a_baddr, 0);
        check("w1_e1_data", a_bdata, 8'h5A);
        check("w1_e1_we", a_we, 0);
        check("w1_e1_level", a_level, 0);
        @(negedge clk);
        check("w1_e2_we", a_we, 1);
        @(negedge clk);
        check("w1_e3_we", a_we, 1);
        @(negedge clk);
        check("w1_e4_we", a_we, 0);
        check("w1_e4_data_held", a_bdata, 8'h5A);
        @(negedge clk);
        check("w1_e5_busy", a_busy, 1);
        @(negedge clk);
        check("w1_e6_busy", a_busy, 0);
        check("w1_e6_voice_held", a_bvoice, 1);
        #1;
        check("w1_rises", a_rise_edge.size(), 1);
        check("w1_rise_edge", a_rise_edge[0], t0 + 2);

        // Burst of six back-to-back writes with backpressure.
        burst_vec[0] = {2'd0, 3'd0, 8'h11};
        burst_vec[1] = {2'd1, 3'd1, 8'h22};
        burst_vec[2] = {2'd2, 3'd2, 8'h33};
        burst_vec[3] = {2'd0, 3'd4, 8'h44};
        burst_vec[4] = {2'd1, 3'd5, 8'h55};
        burst_vec[5] = {2'd2, 3'd6, 8'h66};
        base  = a_rise_edge.size();
        hbase = a_hi_len.size();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            val = burst_vec[i];
            push(0, val[12:11], val[10:8], val[7:0]);
        end
        check("burst_full_level", a_level, 4);
        check("burst_full_ready", a_ready, 0);
        n = 0;
        while (a_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("burst_ready_return", n, 3);
        val = burst_vec[5];
        push(0, val[12:11], val[10:8], val[7:0]);
        wait_idle(0, 100);
        check("burst_rises", a_rise_edge.size() - base, 6);
        if (a_rise_edge.size() - base == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("burst_val%0d", i), a_rise_val[base + i], burst_vec[i]);
                check($sformatf("burst_hi%0d", i), a_hi_len[hbase + i], 2);
                if (i > 0)
                    check($sformatf("burst_gap%0d", i), a_rise_edge[base + i] - a_rise_edge[base + i - 1], 6);
            end
        end

        // Illegal requests are consumed, flagged, and never counted.
        base = a_rise_edge.size();
        push(0, 2'd3, 3'd0, 8'hAA);
        check("ill_voice_bad", a_bad, 1);
        check("ill_voice_level", a_level, 0);
        push(0, 2'd0, 3'd7, 8'hBB);
        check("ill_addr_bad", a_bad, 1);
        check("ill_addr_level", a_level, 0);
        push(0, 2'd2, 3'd1, 8'hCC);
        check("ill_legal_bad", a_bad, 0);
        check("ill_legal_level", a_level, 1);
        wait_idle(0, 50);
        check("ill_rises", a_rise_edge.size() - base, 1);
        if (a_rise_edge.size() - base == 1)
            check("ill_val", a_rise_val[base], {2'd2, 3'd1, 8'hCC});

        // Illegal request on the same edge as a pop: level only decrements.
        base = a_rise_edge.size();
        push(0, 2'd0, 3'd2, 8'hDD);
        check("sim_push_level", a_level, 1);
        push(0, 2'd1, 3'd3, 8'hEE);
        check("sim_pop_level", a_level, 0);
        check("sim_pop_bad", a_bad, 1);
        wait_idle(0, 50);
        check("sim_rises", a_rise_edge.size() - base, 1);

        // Reset while strobing.
        base = a_rise_edge.size();
        push(0, 2'd0, 3'd0, 8'h01);
        push(0, 2'd1, 3'd1, 8'h02);
        push(0, 2'd2, 3'd2, 8'h03);
        check("rms_we_before", a_we, 1);
        check("rms_level_before", a_level, 2);
        #1 rst = 1'b1;
        #1;
        check("rms_we_async", a_we, 0);
        check("rms_level", a_level, 0);
        check("rms_busy", a_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("rms_no_more_strobes", a_rise_edge.size() - base, 1);
        check("rms_idle_busy", a_busy, 0);

        // End-to-end: voice 2 (select 1) gets freq 0x1234 and waveform 0x21 via a capture model.
        for (int v = 0; v < 3; v++)
            for (int r = 0; r < 8; r++)
                regs[v][r] = 8'h00;
        base = a_rise_edge.size();
        @(negedge clk);
        push(0, 2'd1, 3'd0, 8'h34);
        push(0, 2'd1, 3'd1, 8'h12);
        push(0, 2'd1, 3'd4, 8'h21);
        wait_idle(0, 100);
        check("e2e_rises", a_rise_edge.size() - base, 3);
        for (int i = base; i < a_rise_val.size(); i++) begin
            val = a_rise_val[i];
            if (val[12:11] < 2'd3) regs[val[12:11]][val[10:8]] = val[7:0];
        end
        check("e2e_freq", {regs[1][1], regs[1][0]}, 16'h1234);
        check("e2e_wave", regs[1][4], 8'h21);
        other = 8'h00;
        for (int r = 0; r < 8; r++) other = other | regs[0][r] | regs[2][r];
        check("e2e_other_voices", other, 0);

        // Fast timing instance: 4-cycle period, 1-cycle strobes.
        @(negedge clk);
        t0 = edge_cnt + 1;
        push(1, 2'd0, 3'd0, 8'h11);
        push(1, 2'd1, 3'd2, 8'h22);
        push(1, 2'd2, 3'd6, 8'h33);
        check("fast_level", b_level, 2);
        check("fast_bad", b_bad, 0);
        wait_idle(1, 50);
        check("fast_rises", b_rise_edge.size(), 3);
        if (b_rise_edge.size() == 3 && b_hi_len.size() == 3) begin
            check("fast_first_rise", b_rise_edge[0], t0 + 2);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("fast_hi%0d", i), b_hi_len[i], 1);
                if (i > 0)
                    check($sformatf("fast_gap%0d", i), b_rise_edge[i] - b_rise_edge[i - 1], 4);
            end
        end
        check("fast_last_data", b_bdata, 8'h33);
        check("fast_last_voice", b_bvoice, 2);
        check("fast_last_addr", b_baddr, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
